// File: rtl/sim_result_if.sv
// Checker-to-monitor bundle: check events and end request in, verdict and report out.
// The master side belongs to the test harness and the slave side to the result monitor.
interface sim_result_if;
    logic        check_valid;
    logic        check_pass;
    logic [7:0]  check_id;
    logic        end_req;
    logic        sim_success;
    logic        sim_done;
    logic [31:0] sim_report;

    modport master (
        output check_valid, check_pass, check_id, end_req,
        input  sim_success, sim_done, sim_report
    );

    modport slave (
        input  check_valid, check_pass, check_id, end_req,
        output sim_success, sim_done, sim_report
    );
endinterface

// File: rtl/sim_result_monitor.sv
// Counts checker pass/fail events and runs an idle watchdog.
// After an end request plus drain, or after a timeout, it latches a sticky verdict and a final report word.
module sim_result_monitor #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MIN_CHECKS     = 1,
    parameter int HOLDOFF        = 16
) (
    input  logic         clk,
    input  logic         rst,
    sim_result_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DR_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(HOLDOFF - 1);
    localparam logic [15:0]     MIN_CNT = 16'(MIN_CHECKS);

    localparam logic [7:0] TAG_PASS    = 8'hC0;
    localparam logic [7:0] TAG_FAIL    = 8'hF0;
    localparam logic [7:0] TAG_SUCCESS = 8'hD0;
    localparam logic [7:0] TAG_TIMEOUT = 8'hE0;
    localparam logic [7:0] TAG_FAILED  = 8'hDF;

    state_e            state_q,     state_d;
    logic [15:0]       pass_cnt_q,  pass_cnt_d;
    logic              fail_seen_q, fail_seen_d;
    logic [WD_W-1:0]   wdog_q,      wdog_d;
    logic [DR_W-1:0]   drain_q,     drain_d;
    logic              done_q,      done_d;
    logic              success_q,   success_d;
    logic [31:0]       report_q,    report_d;

    logic              check_evt;
    logic              timeout;
    logic              finish;
    logic [7:0]        final_tag;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        fail_seen_d = fail_seen_q;
        wdog_d      = wdog_q;
        drain_d     = drain_q;
        done_d      = done_q;
        success_d   = success_q;
        report_d    = report_q;
        timeout     = 1'b0;
        finish      = 1'b0;
        final_tag   = TAG_FAILED;

        check_evt = mon.check_valid && (state_q != ST_DONE);

        if (check_evt) begin
            if (mon.check_pass) begin
                pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
                report_d   = {TAG_PASS, mon.check_id, pass_cnt_d};
            end else begin
                fail_seen_d = 1'b1;
                report_d    = {TAG_FAIL, mon.check_id, pass_cnt_q};
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (mon.end_req) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else if (!mon.check_valid && (wdog_q == WD_LAST)) begin
                    timeout = 1'b1;
                    finish  = 1'b1;
                end else begin
                    wdog_d = mon.check_valid ? '0 : wdog_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DR_LAST) finish = 1'b1;
                else                    drain_d = drain_q + 1'b1;
            end
            default: ;
        endcase

        // The verdict uses the *_d values, so a check on the final drain cycle is included.
        if (finish) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            success_d = !fail_seen_d && !timeout && (pass_cnt_d >= MIN_CNT);
            if (success_d)    final_tag = TAG_SUCCESS;
            else if (timeout) final_tag = TAG_TIMEOUT;
            report_d  = {final_tag, 8'h00, pass_cnt_d};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pass_cnt_q  <= '0;
            fail_seen_q <= 1'b0;
            wdog_q      <= '0;
            drain_q     <= '0;
            done_q      <= 1'b0;
            success_q   <= 1'b0;
            report_q    <= '0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_seen_q <= fail_seen_d;
            wdog_q      <= wdog_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            success_q   <= success_d;
            report_q    <= report_d;
        end
    end

    assign mon.sim_done    = done_q;
    assign mon.sim_success = success_q;
    assign mon.sim_report  = report_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed bench for sim_result_monitor: a default instance, a short-watchdog instance and a MIN_CHECKS=2 instance.
// Inputs change on the falling edge and outputs are observed there, half a cycle from the active edge.
module tb_sim_result_monitor;

    localparam int HOLDOFF = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sim_result_if m_if ();
    sim_result_if w_if ();
    sim_result_if n_if ();

    sim_result_monitor #(.TIMEOUT_CYCLES(100000), .MIN_CHECKS(1), .HOLDOFF(HOLDOFF)) dut_main (
        .clk(clk), .rst(rst), .mon(m_if)
    );
    sim_result_monitor #(.TIMEOUT_CYCLES(50), .MIN_CHECKS(1), .HOLDOFF(HOLDOFF)) dut_wd (
        .clk(clk), .rst(rst), .mon(w_if)
    );
    sim_result_monitor #(.TIMEOUT_CYCLES(100000), .MIN_CHECKS(2), .HOLDOFF(HOLDOFF)) dut_min (
        .clk(clk), .rst(rst), .mon(n_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic idle_inputs();
        m_if.check_valid = 1'b0; m_if.check_pass = 1'b0; m_if.check_id = 8'h00; m_if.end_req = 1'b0;
        w_if.check_valid = 1'b0; w_if.check_pass = 1'b0; w_if.check_id = 8'h00; w_if.end_req = 1'b0;
        n_if.check_valid = 1'b0; n_if.check_pass = 1'b0; n_if.check_id = 8'h00; n_if.end_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one check to the main instance for one cycle; returns one falling edge later.
    task automatic send_check(input logic pass, input logic [7:0] id);
        m_if.check_valid = 1'b1;
        m_if.check_pass  = pass;
        m_if.check_id    = id;
        @(negedge clk);
        m_if.check_valid = 1'b0;
    endtask

    task automatic wait_done_main(input int limit, output int cycles);
        cycles = 0;
        while (!m_if.sim_done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== 34'h0) begin
                n_bad++;
                $display("FAIL reset_hold: done=%b success=%b report=%h, required 0/0/00000000",
                         m_if.sim_done, m_if.sim_success, m_if.sim_report);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_release: done=%b success=%b report=%h, required 0/0/00000000",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
    endtask

    task automatic test_pass_flow();
        int cycles;
        logic [31:0] exp_rep;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            send_check(1'b1, 8'(i));
            exp_rep = {8'hC0, 8'(i), 16'(i)};
            n_cmp++;
            if (m_if.sim_report !== exp_rep) begin
                n_bad++;
                $display("FAIL pass_report_%0d: got %h, required %h", i, m_if.sim_report, exp_rep);
            end
        end
        // end_req held as a level: the drain must not restart while it stays high.
        m_if.end_req = 1'b1;
        wait_done_main(100, cycles);
        m_if.end_req = 1'b0;
        n_cmp++;
        if (cycles !== HOLDOFF + 1) begin
            n_bad++;
            $display("FAIL pass_done_latency: got %0d cycles, required %0d", cycles, HOLDOFF + 1);
        end
        n_cmp++;
        if (m_if.sim_success !== 1'b1) begin
            n_bad++;
            $display("FAIL pass_success: got %b, required 1", m_if.sim_success);
        end
        n_cmp++;
        if (m_if.sim_report !== 32'hD000_0003) begin
            n_bad++;
            $display("FAIL pass_final_report: got %h, required D0000003", m_if.sim_report);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== {2'b11, 32'hD000_0003}) begin
            n_bad++;
            $display("FAIL pass_sticky: done=%b success=%b report=%h, required 1/1/D0000003",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
    endtask

    task automatic test_fail_flow();
        int cycles;
        do_reset();
        send_check(1'b1, 8'h05);
        send_check(1'b0, 8'h09);
        n_cmp++;
        if (m_if.sim_report !== 32'hF009_0001) begin
            n_bad++;
            $display("FAIL fail_report: got %h, required F0090001", m_if.sim_report);
        end
        m_if.end_req = 1'b1;
        @(negedge clk);
        m_if.end_req = 1'b0;
        wait_done_main(100, cycles);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success} !== 2'b10) begin
            n_bad++;
            $display("FAIL fail_verdict: done=%b success=%b, required 1/0", m_if.sim_done, m_if.sim_success);
        end
        n_cmp++;
        if (m_if.sim_report !== 32'hDF00_0001) begin
            n_bad++;
            $display("FAIL fail_final_report: got %h, required DF000001", m_if.sim_report);
        end
    endtask

    task automatic test_late_check();
        int cycles;
        do_reset();
        send_check(1'b1, 8'h01);
        m_if.end_req = 1'b1;
        @(negedge clk);
        m_if.end_req = 1'b0;
        repeat (2) @(negedge clk);
        send_check(1'b1, 8'h02);
        n_cmp++;
        if (m_if.sim_report !== 32'hC002_0002) begin
            n_bad++;
            $display("FAIL late_report: got %h, required C0020002", m_if.sim_report);
        end
        wait_done_main(100, cycles);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== {2'b11, 32'hD000_0002}) begin
            n_bad++;
            $display("FAIL late_final: done=%b success=%b report=%h, required 1/1/D0000002",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
    endtask

    task automatic test_drain_edge();
        do_reset();
        m_if.end_req = 1'b1;
        repeat (HOLDOFF) @(negedge clk);
        m_if.end_req = 1'b0;
        n_cmp++;
        if (m_if.sim_done !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_edge_early: done=%b on last drain cycle, required 0", m_if.sim_done);
        end
        // Sole pass arrives on the final drain cycle; without it the pass count would be 0.
        send_check(1'b1, 8'h3A);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== {2'b11, 32'hD000_0001}) begin
            n_bad++;
            $display("FAIL drain_edge_final: done=%b success=%b report=%h, required 1/1/D0000001",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_reset();
        m_if.end_req = 1'b1;
        send_check(1'b1, 8'h07);
        m_if.end_req = 1'b0;
        n_cmp++;
        if (m_if.sim_report !== 32'hC007_0001) begin
            n_bad++;
            $display("FAIL same_cycle_report: got %h, required C0070001", m_if.sim_report);
        end
        wait_done_main(100, cycles);
        n_cmp++;
        if (cycles + 1 !== HOLDOFF + 1) begin
            n_bad++;
            $display("FAIL same_cycle_latency: got %0d cycles, required %0d", cycles + 1, HOLDOFF + 1);
        end
        n_cmp++;
        if ({m_if.sim_success, m_if.sim_report} !== {1'b1, 32'hD000_0001}) begin
            n_bad++;
            $display("FAIL same_cycle_final: success=%b report=%h, required 1/D0000001",
                     m_if.sim_success, m_if.sim_report);
        end
        send_check(1'b0, 8'h44);
        @(negedge clk);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== {2'b11, 32'hD000_0001}) begin
            n_bad++;
            $display("FAIL done_ignore: done=%b success=%b report=%h, required 1/1/D0000001",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (49) @(negedge clk);
        n_cmp++;
        if (w_if.sim_done !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_early: done=%b at cycle 49, required 0", w_if.sim_done);
        end
        @(negedge clk);
        n_cmp++;
        if ({w_if.sim_done, w_if.sim_success, w_if.sim_report} !== {2'b10, 32'hE000_0000}) begin
            n_bad++;
            $display("FAIL wdog_fire: done=%b success=%b report=%h, required 1/0/E0000000",
                     w_if.sim_done, w_if.sim_success, w_if.sim_report);
        end
    endtask

    task automatic test_min_checks();
        int cycles;
        do_reset();
        n_if.check_valid = 1'b1; n_if.check_pass = 1'b1; n_if.check_id = 8'h01;
        @(negedge clk);
        n_if.check_valid = 1'b0;
        n_if.end_req     = 1'b1;
        @(negedge clk);
        n_if.end_req     = 1'b0;
        cycles = 0;
        while (!n_if.sim_done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        n_cmp++;
        if ({n_if.sim_done, n_if.sim_success, n_if.sim_report} !== {2'b10, 32'hDF00_0001}) begin
            n_bad++;
            $display("FAIL min_checks: done=%b success=%b report=%h, required 1/0/DF000001",
                     n_if.sim_done, n_if.sim_success, n_if.sim_report);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        send_check(1'b1, 8'h01);
        m_if.end_req = 1'b1;
        @(negedge clk);
        m_if.end_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_success, m_if.sim_report} !== 34'h0) begin
            n_bad++;
            $display("FAIL drain_reset: done=%b success=%b report=%h, required 0/0/00000000",
                     m_if.sim_done, m_if.sim_success, m_if.sim_report);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (HOLDOFF + 4) @(negedge clk);
        n_cmp++;
        if ({m_if.sim_done, m_if.sim_report} !== 33'h0) begin
            n_bad++;
            $display("FAIL drain_reset_after: done=%b report=%h, required 0/00000000",
                     m_if.sim_done, m_if.sim_report);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_pass_flow();
        test_fail_flow();
        test_late_check();
        test_drain_edge();
        test_back_to_back();
        test_watchdog();
        test_min_checks();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
